mem_request_arbiter: RTL
========================

Name: mem_request_arbiter

Overview:
- Shares the single SRAM/Wishbone master port between three clients: CPU, VGA and UART.
- Owns the current-client encoding: CPU=0, VGA=1, UART=2, none=3.
- VGA gets absolute ownership of the bus whenever the display reports pre-active or active.
- CPU and UART are round-robin arbitrated during blanking, with one registered transaction per grant and a timeout guard.

Parameters:
- TIMEOUT, 255, max cycles a CPU/UART transaction may wait on bus_busy before abort.
- CNT_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- vga_state  in  2  display phase: 0 inactive, 1 about to be active, 2 active; 3 treated as 2
- vga_req  in  1  VGA read strobe (its data_en)
- vga_addr  in  32  VGA word address
- vga_busy  out  1  SRAM busy as seen by VGA
- cpu_req, uart_req  in  1 each  level request, held until done/err
- cpu_addr, uart_addr  in  32 each  word address
- cpu_wdata, uart_wdata  in  32 each  write data
- cpu_we, uart_we  in  1 each  1 = write
- cpu_sel, uart_sel  in  4 each  byte select
- cpu_done, uart_done  out  1 each  one-cycle completion pulse
- cpu_err, uart_err  out  1 each  one-cycle timeout pulse
- bus_req  out  1  request/strobe to SRAM controller
- bus_addr  out  32  address to SRAM
- bus_wdata  out  32  write data to SRAM
- bus_we  out  1  write enable to SRAM
- bus_sel  out  4  byte select to SRAM
- bus_busy  in  1  SRAM controller busy
- current_client  out  2  owner encoding (0/1/2/3)

Behaviour:
- Reset (async, nrst low), all applied immediately:
  - state=IDLE, current_client=3, rr pointer=CPU.
  - bus_req/bus_we=0; bus_addr/bus_wdata/bus_sel=0.
  - done/err pulses 0, timeout counter 0.
  - vga_busy=1.
- Reset mid-transaction drops bus_req in the same instant, with no done/err pulse.
- States:
  - IDLE, ISSUE and WAIT are registered; outputs are decoded from registered state plus latched transaction fields.
  - VGA is combinational pass-through, described below.
- IDLE:
  - If vga_state!=0, go to VGA. This takes precedence over any pending CPU/UART request.
  - Else if any of cpu_req/uart_req: grant round-robin. With both requesting, grant the client the rr pointer names. With one requesting, grant it.
  - On grant, latch that client's addr/wdata/we/sel, set current_client, advance rr pointer to the other client, go to ISSUE.
  - Else stay in IDLE with current_client=3.
- ISSUE, exactly 1 cycle:
  - bus_req=1 with the latched fields; counter cleared.
  - Go to WAIT.
- WAIT:
  - bus_req=0; latched fields held.
  - bus_busy=1: counter increments. When counter reaches TIMEOUT, pulse the granted client's err, go to IDLE (or to VGA if vga_state!=0).
  - bus_busy=0: pulse the granted client's done for exactly 1 cycle, go to IDLE (or to VGA if vga_state!=0).
  - Minimum grant-to-done latency: 2 cycles after grant (ISSUE, WAIT).
  - vga_state rising during ISSUE/WAIT does not abort the transfer; VGA waits until it completes.
- VGA:
  - current_client=1.
  - bus_req=vga_req, bus_addr=vga_addr, bus_we=0, bus_sel={4{vga_req}}, bus_wdata=0.
  - vga_busy=bus_busy, combinational, same cycle.
  - In every other state vga_busy=1.
  - CPU/UART requests stall with no pulses.
  - Leave to IDLE on the first cycle vga_state==0; CPU/UART may be granted the following cycle.
- Request dropped before grant: ignored, no pulse. Request dropped after grant: transaction still completes and done still pulses.
- Counter width is CNT_W; it saturates, never wraps.

Test Plan:
- Single CPU read: vga_state=0, cpu_req=1, addr=0x40, we=0.
  - current_client=0 at grant+1; bus_req high for exactly 1 cycle with bus_addr=0x40.
  - bus_busy held 3 cycles then low: cpu_done pulses once, current_client returns to 3.
- Simultaneous CPU+UART requests after reset, both held:
  - CPU served first, then UART, then CPU; grants alternate.
  - uart_wdata=0xDEADBEEF with sel=0xF appears on bus_wdata/bus_sel in the UART ISSUE cycle.
- VGA preemption: CPU in WAIT with bus_busy=1 when vga_state goes to 1.
  - CPU transfer completes and cpu_done pulses.
  - Next cycle current_client=1 and bus_addr follows vga_addr=0x3E80.
  - A pending uart_req receives no grant until vga_state=0.
- VGA pass-through: vga_state=2, vga_req toggling, bus_busy toggling.
  - bus_req=vga_req, bus_sel=0xF/0x0 and vga_busy=bus_busy every cycle, zero latency.
  - vga_state=0 gives current_client=3 and vga_busy=1 the next cycle.
- Timeout: TIMEOUT=4, cpu_req with bus_busy stuck at 1.
  - cpu_err pulses once on the 4th WAIT cycle; cpu_done never asserts; state returns to IDLE.
- Async reset in WAIT: nrst low mid-cycle.
  - bus_req=0, current_client=3 and vga_busy=1 immediately; no done/err pulse.
  - After release the first grant goes to CPU.

Source files
------------

// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter
//
// Shares the single SRAM master port between the CPU, VGA and UART clients.
// While the display is about to be active or is active (vga_state != 0) the
// VGA client owns the bus outright through a combinational pass-through.
// During blanking the CPU and UART are served round-robin, one registered
// transaction per grant (ISSUE strobe, then WAIT for bus_busy to drop),
// with a saturating timeout counter that aborts a stuck transfer.
//
// Ports:
//   clk, nrst                 clock, asynchronous active-low reset
//   vga_state[1:0]            0 inactive, 1 pre-active, 2/3 active
//   vga_req, vga_addr         VGA read strobe and word address
//   vga_busy                  SRAM busy as seen by VGA (1 unless VGA owns bus)
//   cpu_* / uart_*            level request, addr, wdata, we, sel;
//                             done/err are one-cycle completion/timeout pulses
//   bus_req/addr/wdata/we/sel master port towards the SRAM controller
//   bus_busy                  SRAM controller busy
//   current_client[1:0]       owner: 0 CPU, 1 VGA, 2 UART, 3 none
module mem_request_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [1:0]  vga_state,
  input  logic        vga_req,
  input  logic [31:0] vga_addr,
  output logic        vga_busy,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_sel,
  output logic        cpu_done,
  output logic        cpu_err,
  input  logic        uart_req,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_wdata,
  input  logic        uart_we,
  input  logic [3:0]  uart_sel,
  output logic        uart_done,
  output logic        uart_err,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  input  logic        bus_busy,
  output logic [1:0]  current_client
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_VGA   = 2'd3
  } state_t;

  localparam logic [CNT_W:0] TIMEOUT_VAL = (CNT_W + 1)'(TIMEOUT);

  // Round-robin participants: index 0 = CPU, index 1 = UART.
  logic [1:0]  cl_req;
  logic [31:0] cl_addr  [2];
  logic [31:0] cl_wdata [2];
  logic        cl_we    [2];
  logic [3:0]  cl_sel   [2];
  logic [1:0]  cl_done;
  logic [1:0]  cl_err;

  assign cl_req      = {uart_req, cpu_req};
  assign cl_addr[0]  = cpu_addr;
  assign cl_addr[1]  = uart_addr;
  assign cl_wdata[0] = cpu_wdata;
  assign cl_wdata[1] = uart_wdata;
  assign cl_we[0]    = cpu_we;
  assign cl_we[1]    = uart_we;
  assign cl_sel[0]   = cpu_sel;
  assign cl_sel[1]   = uart_sel;

  state_t           state_reg, state_next;
  logic             grant_reg, grant_next;  // granted participant index
  logic             rr_reg, rr_next;        // preferred participant on a tie
  logic [31:0]      addr_reg, addr_next;
  logic [31:0]      wdata_reg, wdata_next;
  logic             we_reg, we_next;
  logic [3:0]       sel_reg, sel_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic             vga_active;
  logic             pick;
  logic [CNT_W:0]   cnt_plus;
  logic             timeout_hit;
  logic             wait_done;
  logic             wait_err;

  assign vga_active = (vga_state != 2'd0);
  // With both requesting the rr pointer decides; otherwise the sole requester.
  assign pick       = (&cl_req) ? rr_reg : cl_req[1];
  // Timeout fires in the WAIT cycle whose busy sample brings the count to TIMEOUT.
  assign cnt_plus    = {1'b0, cnt_reg} + {{CNT_W{1'b0}}, 1'b1};
  assign timeout_hit = bus_busy && (cnt_plus >= TIMEOUT_VAL);
  assign wait_done   = (state_reg == ST_WAIT) && !bus_busy;
  assign wait_err    = (state_reg == ST_WAIT) && timeout_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_client
      assign cl_done[gi] = wait_done && (grant_reg == 1'(gi));
      assign cl_err[gi]  = wait_err  && (grant_reg == 1'(gi));
    end
  endgenerate

  assign cpu_done  = cl_done[0];
  assign uart_done = cl_done[1];
  assign cpu_err   = cl_err[0];
  assign uart_err  = cl_err[1];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= ST_IDLE;
      grant_reg <= 1'b0;
      rr_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
      sel_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      rr_reg    <= rr_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      we_reg    <= we_next;
      sel_reg   <= sel_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    rr_next    = rr_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    we_next    = we_reg;
    sel_next   = sel_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (vga_active) begin
          state_next = ST_VGA;
        end else if (|cl_req) begin
          grant_next = pick;
          rr_next    = ~pick;
          addr_next  = cl_addr[pick];
          wdata_next = cl_wdata[pick];
          we_next    = cl_we[pick];
          sel_next   = cl_sel[pick];
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_next   = '0;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // A rising vga_state never aborts; VGA only takes over once done/err.
        if (bus_busy && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_next = cnt_reg + 1'b1;
        end
        if (!bus_busy || timeout_hit) begin
          state_next = vga_active ? ST_VGA : ST_IDLE;
        end
      end
      ST_VGA: begin
        if (!vga_active) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_req        = 1'b0;
    bus_addr       = addr_reg;
    bus_wdata      = wdata_reg;
    bus_we         = we_reg;
    bus_sel        = sel_reg;
    vga_busy       = 1'b1;
    current_client = 2'd3;
    case (state_reg)
      ST_ISSUE: begin
        bus_req        = 1'b1;
        current_client = grant_reg ? 2'd2 : 2'd0;
      end
      ST_WAIT: begin
        current_client = grant_reg ? 2'd2 : 2'd0;
      end
      ST_VGA: begin
        bus_req        = vga_req;
        bus_addr       = vga_addr;
        bus_wdata      = '0;
        bus_we         = 1'b0;
        bus_sel        = {4{vga_req}};
        vga_busy       = bus_busy;
        current_client = 2'd1;
      end
      default: ;
    endcase
  end

endmodule
